// File: rtl/mdu_iter.sv
// mdu_iter: multi-cycle multiply/divide unit for the EX-stage HI/LO register.
// Signed operations run on operand magnitudes and fix the signs at the end.
// Multiply is shift-add, one multiplier bit per cycle, unless MUL_FAST is set.
// Divide is radix-2 restoring, one quotient bit per cycle, MSB first.
// A zero divisor skips the iteration and finishes in one cycle with dz set.
module mdu_iter #(
    parameter int WIDTH    = 32,
    parameter bit MUL_FAST = 1'b0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             annul,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             dz
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             neg_lo_q, neg_lo_d;   // negate product / quotient
    logic             neg_hi_q, neg_hi_d;   // negate remainder
    logic [WIDTH-1:0] mag_q, mag_d;         // multiplicand or divisor magnitude
    logic [WIDTH:0]   acc_hi_q, acc_hi_d;   // partial product high / remainder
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;   // multiplier / dividend -> quotient
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             dz_q, dz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // operand decode at launch: op[0]=1 means unsigned
    logic             sgn_in, a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [2*WIDTH-1:0] fast_prod, fast_fix;

    // one iteration of the shift-add multiply and restoring divide
    logic [WIDTH:0]     mul_sum, mul_hi;
    logic [WIDTH-1:0]   mul_lo;
    logic [WIDTH:0]     div_rs, div_hi;
    logic [WIDTH-1:0]   div_lo;
    logic               div_ge;
    logic [WIDTH:0]     step_hi;
    logic [WIDTH-1:0]   step_lo;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // magnitudes of the incoming operands and the single-cycle product
    always_comb begin
        sgn_in    = ~op[0];
        a_neg     = sgn_in & src_a[WIDTH-1];
        b_neg     = sgn_in & src_b[WIDTH-1];
        mag_a     = a_neg ? -src_a : src_a;
        mag_b     = b_neg ? -src_b : src_b;
        fast_prod = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
        fast_fix  = (a_neg ^ b_neg) ? -fast_prod : fast_prod;
    end

    // datapath step and the sign-corrected result of the final step
    always_comb begin
        mul_sum = acc_hi_q + (acc_lo_q[0] ? {1'b0, mag_q} : '0);
        mul_hi  = {1'b0, mul_sum[WIDTH:1]};
        mul_lo  = {mul_sum[0], acc_lo_q[WIDTH-1:1]};

        div_rs  = {acc_hi_q[WIDTH-1:0], acc_lo_q[WIDTH-1]};
        div_ge  = (div_rs >= {1'b0, mag_q});
        div_hi  = div_ge ? (div_rs - {1'b0, mag_q}) : div_rs;
        div_lo  = {acc_lo_q[WIDTH-2:0], div_ge};

        step_hi = is_div_q ? div_hi : mul_hi;
        step_lo = is_div_q ? div_lo : mul_lo;

        prod     = {step_hi[WIDTH-1:0], step_lo};
        prod_fix = neg_lo_q ? -prod : prod;
        quo_fix  = neg_lo_q ? -step_lo : step_lo;
        rem_fix  = neg_hi_q ? -step_hi[WIDTH-1:0] : step_hi[WIDTH-1:0];
    end

    // FSM next state: launch, iterate, finish; annul only acts in RUN
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        mag_d    = mag_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dz_d     = dz_q;
        case (state_q)
            S_IDLE: begin
                if (start && !annul) begin
                    is_div_d = op[1];
                    neg_lo_d = a_neg ^ b_neg;
                    neg_hi_d = a_neg;
                    cnt_d    = CW'(WIDTH - 1);
                    mag_d    = op[1] ? mag_b : mag_a;
                    acc_hi_d = '0;
                    acc_lo_d = op[1] ? mag_a : mag_b;
                    if (op[1] && (src_b == '0)) begin
                        // divide by zero: dividend passes through untouched
                        hi_d    = src_a;
                        lo_d    = '1;
                        dz_d    = 1'b1;
                        state_d = S_DONE;
                    end else if (!op[1] && MUL_FAST) begin
                        {hi_d, lo_d} = fast_fix;
                        dz_d         = 1'b0;
                        state_d      = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (annul) begin
                    // flush wins over a completion in the same cycle
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    acc_hi_d = step_hi;
                    acc_lo_d = step_lo;
                    cnt_d    = cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        cnt_d   = '0;
                        state_d = S_DONE;
                        dz_d    = 1'b0;
                        if (is_div_q) begin
                            hi_d = rem_fix;
                            lo_d = quo_fix;
                        end else begin
                            {hi_d, lo_d} = prod_fix;
                        end
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // all state, reset asynchronously to idle with cleared results
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            mag_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            dz_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            mag_q    <= mag_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            dz_q     <= dz_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
    assign dz   = dz_q;

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed vectors for mdu_iter, iterative and fast-multiply builds
// side by side, plus hand sequences for annul, busy-start and async reset.
module tb_mdu_iter;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         start = 1'b0;
    logic         annul = 1'b0;
    logic [1:0]   op = 2'd0;
    logic [W-1:0] src_a = '0;
    logic [W-1:0] src_b = '0;
    logic         busy, done, dz, f_busy, f_done, f_dz;
    logic [W-1:0] hi, lo, f_hi, f_lo;

    mdu_iter #(.WIDTH(W), .MUL_FAST(1'b0)) u_dut (
        .clk(clk), .resetn(resetn), .start(start), .op(op), .annul(annul),
        .src_a(src_a), .src_b(src_b), .busy(busy), .done(done),
        .hi(hi), .lo(lo), .dz(dz));

    mdu_iter #(.WIDTH(W), .MUL_FAST(1'b1)) u_fast (
        .clk(clk), .resetn(resetn), .start(start), .op(op), .annul(annul),
        .src_a(src_a), .src_b(src_b), .busy(f_busy), .done(f_done),
        .hi(f_hi), .lo(f_lo), .dz(f_dz));

    always #5 clk = ~clk;

    int cmp_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a, b, ehi, elo;
        logic         edz;
        int           lat, flat;
    } vec_t;
    vec_t vecs[14];

    int           lat, flat, gaps, dcnt, got, extra;
    logic [W-1:0] rh, rl, fh, fl;
    logic         rdz, fdz, b10, b11;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // launch at the current negedge (cycle 0), return at the negedge of the
    // cycle after the later done pulse so a following start is back-to-back
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int l, output logic [W-1:0] h_o, output logic [W-1:0] l_o,
                          output logic d_o, output int fl_o, output logic [W-1:0] fh_o,
                          output logic [W-1:0] flo_o, output logic fd_o, output int g);
        int n;
        l = -1; fl_o = -1; g = 0;
        h_o = '0; l_o = '0; d_o = 1'b0; fh_o = '0; flo_o = '0; fd_o = 1'b0;
        op = o; src_a = a; src_b = b; start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        while (n <= 40 && (l < 0 || fl_o < 0)) begin
            if (l < 0 && !busy) g++;
            if (done && l < 0) begin
                l = n; h_o = hi; l_o = lo; d_o = dz;
            end
            if (f_done && fl_o < 0) begin
                fl_o = n; fh_o = f_hi; flo_o = f_lo; fd_o = f_dz;
            end
            tick();
            n++;
        end
    endtask

    initial begin
        vecs[0]  = '{2'd0, 32'hFFFFFFFD, 32'h5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33, 1};
        vecs[1]  = '{2'd3, 32'd100,      32'd7,        32'h2,        32'hE,        1'b0, 33, 33};
        vecs[2]  = '{2'd2, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33, 33};
        vecs[3]  = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0, 33, 33};
        vecs[4]  = '{2'd2, 32'h12345678, 32'h0,        32'h12345678, 32'hFFFFFFFF, 1'b1, 1,  1};
        vecs[5]  = '{2'd1, 32'h2,        32'h3,        32'h0,        32'h6,        1'b0, 33, 1};
        vecs[6]  = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1,        1'b0, 33, 1};
        vecs[7]  = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0,        1'b0, 33, 1};
        vecs[8]  = '{2'd2, 32'h7,        32'hFFFFFFFE, 32'h1,        32'hFFFFFFFD, 1'b0, 33, 33};
        vecs[9]  = '{2'd3, 32'hFFFFFFFF, 32'hA,        32'h5,        32'h19999999, 1'b0, 33, 33};
        vecs[10] = '{2'd3, 32'h5,        32'h9,        32'h5,        32'h0,        1'b0, 33, 33};
        vecs[11] = '{2'd3, 32'h0,        32'h0,        32'h0,        32'hFFFFFFFF, 1'b1, 1,  1};
        vecs[12] = '{2'd0, 32'h7,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b0, 33, 1};
        vecs[13] = '{2'd2, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h3,        1'b0, 33, 33};

        // reset state
        repeat (2) @(negedge clk);
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        check("reset hi", {32'd0, hi}, 64'd0);
        check("reset lo", {32'd0, lo}, 64'd0);
        check("reset dz", {63'd0, dz}, 64'd0);
        resetn = 1'b1;

        // table-driven vectors, issued back-to-back
        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, rh, rl, rdz, flat, fh, fl, fdz, gaps);
            check($sformatf("v%0d lat", i), 64'(lat), 64'(vecs[i].lat));
            check($sformatf("v%0d hi", i), {32'd0, rh}, {32'd0, vecs[i].ehi});
            check($sformatf("v%0d lo", i), {32'd0, rl}, {32'd0, vecs[i].elo});
            check($sformatf("v%0d dz", i), {63'd0, rdz}, {63'd0, vecs[i].edz});
            check($sformatf("v%0d busy gaps", i), 64'(gaps), 64'd0);
            check($sformatf("v%0d busy after", i), {63'd0, busy}, 64'd0);
            check($sformatf("v%0d fast lat", i), 64'(flat), 64'(vecs[i].flat));
            check($sformatf("v%0d fast hi", i), {32'd0, fh}, {32'd0, vecs[i].ehi});
            check($sformatf("v%0d fast lo", i), {32'd0, fl}, {32'd0, vecs[i].elo});
            check($sformatf("v%0d fast dz", i), {63'd0, fdz}, {63'd0, vecs[i].edz});
        end

        // start while busy ignored; input changes after launch ignored
        op = 2'd3; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
        got = -1; extra = 0; rh = '0; rl = '0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            start = (c == 5);
            if (c == 1) begin op = 2'd0; src_a = 32'd55; src_b = 32'd3; end
            if (done) begin
                if (got < 0) begin got = c; rh = hi; rl = lo; end
                else extra++;
            end
        end
        start = 1'b0;
        check("busy-start lat", 64'(got), 64'd33);
        check("busy-start lo", {32'd0, rl}, 64'hE);
        check("busy-start hi", {32'd0, rh}, 64'h2);
        check("busy-start extra done", 64'(extra), 64'd0);

        // annul in cycle 10 of a divu
        op = 2'd3; src_a = 32'hFFFF; src_b = 32'd3; start = 1'b1;
        dcnt = 0; b10 = 1'b0; b11 = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            start = 1'b0;
            annul = (c == 10);
            if (c == 10) b10 = busy;
            if (c == 11) b11 = busy;
            if (done) dcnt++;
        end
        annul = 1'b0;
        check("annul busy c10", {63'd0, b10}, 64'd1);
        check("annul busy c11", {63'd0, b11}, 64'd0);
        check("annul no done", 64'(dcnt), 64'd0);
        check("annul hi held", {32'd0, hi}, 64'h2);
        check("annul lo held", {32'd0, lo}, 64'hE);

        // annul in the last RUN cycle beats completion
        op = 2'd0; src_a = 32'd3; src_b = 32'd3; start = 1'b1;
        dcnt = 0; b11 = 1'b1;
        for (int c = 1; c <= 36; c++) begin
            tick();
            start = 1'b0;
            annul = (c == 32);
            if (c == 33) b11 = busy;
            if (done) dcnt++;
        end
        annul = 1'b0;
        check("late annul busy c33", {63'd0, b11}, 64'd0);
        check("late annul no done", 64'(dcnt), 64'd0);
        check("late annul lo held", {32'd0, lo}, 64'hE);

        // start together with annul is dropped
        op = 2'd3; src_a = 32'd9; src_b = 32'd2; start = 1'b1; annul = 1'b1;
        tick();
        start = 1'b0; annul = 1'b0;
        check("start+annul busy", {63'd0, busy}, 64'd0);
        dcnt = 0;
        for (int c = 2; c <= 36; c++) begin
            tick();
            if (done || busy) dcnt++;
        end
        check("start+annul quiet", 64'(dcnt), 64'd0);

        // annul during the done cycle does not cancel the result
        op = 2'd2; src_a = 32'hABCD; src_b = 32'd0; start = 1'b1;
        tick();
        start = 1'b0; annul = 1'b1;
        check("done-annul done", {63'd0, done}, 64'd1);
        check("done-annul hi", {32'd0, hi}, 64'hABCD);
        check("done-annul dz", {63'd0, dz}, 64'd1);
        tick();
        annul = 1'b0;
        check("done-annul busy after", {63'd0, busy}, 64'd0);
        check("done-annul lo held", {32'd0, lo}, 64'hFFFFFFFF);

        // async reset mid-operation, then a normal operation
        op = 2'd2; src_a = 32'd1000; src_b = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (19) tick();
        #3 resetn = 1'b0;
        #1;
        check("rst busy/done/dz", {61'd0, busy, done, dz}, 64'd0);
        check("rst hi", {32'd0, hi}, 64'd0);
        check("rst lo", {32'd0, lo}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        run_op(2'd3, 32'd1000, 32'd3, lat, rh, rl, rdz, flat, fh, fl, fdz, gaps);
        check("post-rst lat", 64'(lat), 64'd33);
        check("post-rst lo", {32'd0, rl}, 64'd333);
        check("post-rst hi", {32'd0, rh}, 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
